synth_mixer: RTL and testbench
==============================

Name: synth_mixer

Overview:
- Parametrised successor to the single-channel subsample accumulator at the synth top level.
- Sums per-voice subsamples from the core into NUM_CHANNELS output channels, routed by a per-voice channel mask register file.
- Scales each completed frame, optionally saturates it, and queues it in a small FIFO.
- Presents queued frames to the DAC/PWM stage with a valid/ready handshake.

Parameters:
- NUM_VOICES, 16, voices per frame; GUARD_BITS = $clog2(NUM_VOICES) (localparam)
- SUBSAMPLE_WIDTH, 16, signed subsample width; ACC_WIDTH = SUBSAMPLE_WIDTH + GUARD_BITS (localparam)
- SAMPLE_WIDTH, 16, signed output width per channel
- NUM_CHANNELS, 2, output channels (1 = mono)
- OUTPUT_SHIFT, 4, arithmetic right shift applied to the accumulator before output
- FIFO_DEPTH, 4, output frame FIFO depth (power of two, at least 2)

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Subsample  in  SUBSAMPLE_WIDTH  signed subsample from core
- i_SubsampleVoice  in  $clog2(NUM_VOICES)  voice index of i_Subsample
- i_SubsampleValid  in  1  subsample strobe
- i_FrameEnd  in  1  last subsample of frame; qualified by i_SubsampleValid
- i_MaskWriteEnable  in  1  channel-mask write strobe
- i_MaskVoice  in  $clog2(NUM_VOICES)  voice whose mask is written
- i_MaskValue  in  NUM_CHANNELS  bit c=1 routes voice to channel c
- o_Sample  out  NUM_CHANNELS*SAMPLE_WIDTH  FIFO head; channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- o_SampleValid  out  1  FIFO non-empty
- i_SampleReady  in  1  consumer accepts o_Sample
- o_FrameDropped  out  1  one-cycle pulse: completed frame lost, FIFO full
- o_DropCount  out  8  saturating count of dropped frames
- o_Clipped  out  1  one-cycle pulse when a pushed frame saturated (macro only; else tied 0)

Behaviour:
- Reset (async assert, synchronous deassert at i_Clock):
  - accumulators 0; masks all-ones; FIFO empty.
  - o_Sample 0, o_SampleValid 0, o_FrameDropped 0, o_DropCount 0, o_Clipped 0.
  - Reset mid-frame discards the partial frame and any frame in the pipeline.
- Accumulate: on a cycle with i_SubsampleValid, each channel c with mask[voice][c]=1 adds the sign-extended subsample into acc[c] (ACC_WIDTH, wraps internally).
- Frame end (cycle N: i_SubsampleValid and i_FrameEnd):
  - the final sum includes cycle N's subsample.
  - at the end of N: result register <= final sums, accumulators <= 0.
  - a valid subsample in N+1 starts the next frame.
- Scaling: value = acc >>> OUTPUT_SHIFT (arithmetic). Without the macro, o_Sample takes the low SAMPLE_WIDTH bits.
- Push: at the end of N+1, the scaled result is written to the FIFO. o_SampleValid rises in N+2 at the earliest.
- Pop: a cycle with o_SampleValid and i_SampleReady pops the head; the next head is visible the following cycle. Show-ahead: o_Sample is valid whenever o_SampleValid is high.
- FIFO full:
  - A push while full and not popping is dropped: o_FrameDropped pulses in N+2, o_DropCount increments, saturating at 255.
  - Push and pop in the same cycle while full is accepted; no drop.
- Pop when empty: ignored.
- Mask write: takes effect the cycle after the write. A subsample for the same voice in the write cycle uses the old mask.
- i_FrameEnd without i_SubsampleValid is ignored.
- Voice indices at or above NUM_VOICES: subsample ignored (still counts as frame end if flagged).

Optional Feature:
- Macro: SYNTH_MIXER_SATURATE_EN.
- Defined: each scaled channel value is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]. o_Clipped pulses in N+2 if any channel was clamped, coincident with the push, including a dropped push.
- Undefined: truncation wraps, and o_Clipped is constant 0.

Test Plan:
- Saturating sum, defaults: 16 subsamples of 0x1000, all masks 11, FrameEnd on the 16th -> o_SampleValid 2 cycles later, both channels 0x1000.
- Mask routing: mask[0]=01, mask[1]=10; voice0=1600, voice1=-320 with FrameEnd -> ch0=0x0064, ch1=0xFFEC. Mask write coincident with voice0's subsample -> old mask used.
- Overflow, OUTPUT_SHIFT=2: 16 subsamples of 32767 -> with SYNTH_MIXER_SATURATE_EN: 0x7FFF and o_Clipped pulse. Without: 0xFFFC, o_Clipped 0.
- Back-pressure: i_SampleReady low, 5 frames (values 1..5 x16) -> frames 1..4 held, 5th dropped, o_FrameDropped one pulse, o_DropCount=1. Raising ready pops 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, pop in the push cycle -> no drop, FIFO remains full, new frame at tail.
- Mid-frame reset: assert i_Reset_n low after 7 subsamples -> outputs 0 immediately. The next full 16-subsample frame equals its own sum only.

Source files
------------

// File: rtl/synth_mixer.sv
// synth_mixer: routes per-voice subsamples into NUM_CHANNELS accumulators,
// scales each finished frame and queues it for the DAC/PWM consumer.
//
// Ports:
//   i_Clock, i_Reset_n          clock, async active-low reset
//   i_Subsample/_Voice/_Valid   subsample stream from the core
//   i_FrameEnd                  last subsample of a frame (with valid)
//   i_MaskWriteEnable/_Voice/_Value  per-voice channel routing mask
//   o_Sample/o_SampleValid      show-ahead FIFO head, valid/ready with
//   i_SampleReady               the consumer
//   o_FrameDropped/o_DropCount  lost-frame pulse and saturating count
//   o_Clipped                   pushed frame was clamped
//
// Optional: define SYNTH_MIXER_SATURATE_EN to clamp each scaled channel
// to the signed SAMPLE_WIDTH range and drive o_Clipped; otherwise the
// scaled value is truncated and o_Clipped is tied low.
module synth_mixer #(
  parameter int NUM_VOICES      = 16,
  parameter int SUBSAMPLE_WIDTH = 16,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int NUM_CHANNELS    = 2,
  parameter int OUTPUT_SHIFT    = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [SUBSAMPLE_WIDTH-1:0] i_Subsample,
  input  logic [$clog2(NUM_VOICES)-1:0] i_SubsampleVoice,
  input  logic                      i_SubsampleValid,
  input  logic                      i_FrameEnd,
  input  logic                      i_MaskWriteEnable,
  input  logic [$clog2(NUM_VOICES)-1:0] i_MaskVoice,
  input  logic [NUM_CHANNELS-1:0]   i_MaskValue,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] o_Sample,
  output logic                      o_SampleValid,
  input  logic                      i_SampleReady,
  output logic                      o_FrameDropped,
  output logic [7:0]                o_DropCount,
  output logic                      o_Clipped
);

  localparam int GUARD_BITS = $clog2(NUM_VOICES);
  localparam int ACC_WIDTH  = SUBSAMPLE_WIDTH + GUARD_BITS;
  localparam int VW         = $clog2(NUM_VOICES);
  localparam int FW         = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int XW         =
    ((ACC_WIDTH > SAMPLE_WIDTH) ? ACC_WIDTH : SAMPLE_WIDTH) + 1;

  localparam logic [VW:0] NV = (VW+1)'(NUM_VOICES);

  // ---------------- mask register file ----------------
  logic [NUM_CHANNELS-1:0] mask_q [NUM_VOICES];
  logic                    voice_ok;
  logic                    mvoice_ok;
  logic [NUM_CHANNELS-1:0] route;

  assign voice_ok  = {1'b0, i_SubsampleVoice} < NV;
  assign mvoice_ok = {1'b0, i_MaskVoice} < NV;

  // Read before the write lands: a same-cycle write uses the old mask.
  assign route = (i_SubsampleValid && voice_ok)
               ? mask_q[i_SubsampleVoice] : '0;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++)
        mask_q[v] <= '1;
    end else if (i_MaskWriteEnable && mvoice_ok) begin
      mask_q[i_MaskVoice] <= i_MaskValue;
    end
  end

  // ---------------- accumulate stage ----------------
  logic signed [ACC_WIDTH-1:0] sub_ext;
  logic signed [ACC_WIDTH-1:0] acc_q   [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] acc_sum [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] res_q   [NUM_CHANNELS];
  logic                        res_v_q;
  logic                        frame_end;

  assign sub_ext   = ACC_WIDTH'($signed(i_Subsample));
  assign frame_end = i_SubsampleValid & i_FrameEnd;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc_sum[c] = acc_q[c];
      if (route[c])
        acc_sum[c] = acc_q[c] + sub_ext;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      res_v_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      res_v_q <= frame_end;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (frame_end) begin
          res_q[c] <= acc_sum[c];
          acc_q[c] <= '0;
        end else begin
          acc_q[c] <= acc_sum[c];
        end
      end
    end
  end

  // ---------------- scale stage ----------------
  logic [FW-1:0] scaled;
  logic          clip_any;

`ifdef SYNTH_MIXER_SATURATE_EN
  localparam logic signed [XW-1:0] SMAX =
    {{(XW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN =
    {{(XW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic signed [XW-1:0] shf [NUM_CHANNELS];
  logic signed [XW-1:0] lim [NUM_CHANNELS];

  always_comb begin
    scaled   = '0;
    clip_any = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      shf[c] = XW'(res_q[c]) >>> OUTPUT_SHIFT;
      lim[c] = shf[c];
      if (shf[c] > SMAX) begin
        lim[c]   = SMAX;
        clip_any = 1'b1;
      end else if (shf[c] < SMIN) begin
        lim[c]   = SMIN;
        clip_any = 1'b1;
      end
      scaled[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        SAMPLE_WIDTH'(lim[c]);
    end
  end
`else
  always_comb begin
    scaled   = '0;
    clip_any = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      // Truncation keeps the low bits; overflow wraps.
      scaled[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        SAMPLE_WIDTH'(XW'(res_q[c]) >>> OUTPUT_SHIFT);
    end
  end
`endif

  // ---------------- output FIFO ----------------
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && i_SampleReady;
  // Full but popping frees the head slot, which is the one written.
  assign push_ok = res_v_q && (!full || pop);
  assign drop    = res_v_q && full && !pop;

  always_ff @(posedge i_Clock) begin
    if (push_ok)
      mem_q[wr_q[AW-1:0]] <= scaled;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
    end
  end

  assign o_SampleValid = !empty;
  assign o_Sample      = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // ---------------- status ----------------
  logic       drop_q;
  logic [7:0] cnt_q;
  logic       clip_q;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      drop_q <= 1'b0;
      cnt_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      drop_q <= drop;
      clip_q <= res_v_q && clip_any;
      if (drop && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign o_FrameDropped = drop_q;
  assign o_DropCount    = cnt_q;

`ifdef SYNTH_MIXER_SATURATE_EN
  assign o_Clipped = clip_q;
`else
  assign o_Clipped = 1'b0;
`endif

endmodule

// File: tb/tb_synth_mixer.sv
// tb_synth_mixer: directed stimulus against a frame-level model of
// the mixer, plus literal expectations for the key frames.
module tb_synth_mixer;

  localparam int NV = 16;
  localparam int SW = 16;
  localparam int NC = 2;
  localparam int SH = 2;
  localparam int FD = 4;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] sub = '0;
  logic [3:0] svc = '0;
  logic sv = 1'b0;
  logic fe = 1'b0;
  logic mwe = 1'b0;
  logic [3:0] mv = '0;
  logic [1:0] mval = '0;
  logic rdy = 1'b0;
  logic [31:0] o_Sample;
  logic o_SampleValid;
  logic o_FrameDropped;
  logic [7:0] o_DropCount;
  logic o_Clipped;

  always #5 clk = ~clk;

  synth_mixer #(
    .NUM_VOICES(NV), .SUBSAMPLE_WIDTH(16),
    .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC),
    .OUTPUT_SHIFT(SH), .FIFO_DEPTH(FD)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_Subsample(sub),
    .i_SubsampleVoice(svc),
    .i_SubsampleValid(sv),
    .i_FrameEnd(fe),
    .i_MaskWriteEnable(mwe),
    .i_MaskVoice(mv),
    .i_MaskValue(mval),
    .o_Sample(o_Sample),
    .o_SampleValid(o_SampleValid),
    .i_SampleReady(rdy),
    .o_FrameDropped(o_FrameDropped),
    .o_DropCount(o_DropCount),
    .o_Clipped(o_Clipped)
  );

  // ---------------- model ----------------
  longint      macc [NC];
  logic [1:0]  mmask [NV];
  logic [31:0] mq [$];
  logic        pend_v;
  logic [31:0] pend_f;
  logic        pend_c;
  logic        e_drop;
  logic        e_clip;
  int          e_cnt;
  int checks = 0;
  int errors = 0;

  function automatic longint wrapa(input longint x);
    logic [AW-1:0] t;
    t = x[AW-1:0];
    return longint'($signed(t));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) macc[c] = 0;
    for (int v = 0; v < NV; v++) mmask[v] = 2'b11;
    mq.delete();
    pend_v = 0; pend_f = '0; pend_c = 0;
    e_drop = 0; e_clip = 0; e_cnt = 0;
  endtask

  // Advance the model over one clock edge using the driven inputs.
  task automatic model_step();
    bit pop;
    bit acc;
    longint x;
    pop = (mq.size() > 0) && rdy;
    acc = 0;
    e_drop = 0;
    e_clip = 0;
    if (pend_v) begin
      e_clip = pend_c;
      if (mq.size() < FD || pop) acc = 1;
      else begin
        e_drop = 1;
        if (e_cnt < 255) e_cnt++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(pend_f);
    pend_v = 0;
    if (sv && int'(svc) < NV)
      for (int c = 0; c < NC; c++)
        if (mmask[svc][c])
          macc[c] = wrapa(macc[c] + longint'(sub));
    if (sv && fe) begin
      pend_v = 1;
      pend_c = 0;
      for (int c = 0; c < NC; c++) begin
        x = macc[c] >>> SH;
`ifdef SYNTH_MIXER_SATURATE_EN
        if (x > 32767) begin x = 32767; pend_c = 1; end
        else if (x < -32768) begin x = -32768; pend_c = 1; end
`endif
        pend_f[c*SW +: SW] = x[SW-1:0];
        macc[c] = 0;
      end
    end
    if (mwe) mmask[mv] = mval;
  endtask

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check();
    cmp("valid", {31'd0, o_SampleValid},
        {31'd0, mq.size() > 0});
    if (mq.size() > 0) cmp("sample", o_Sample, mq[0]);
    cmp("dropped", {31'd0, o_FrameDropped}, {31'd0, e_drop});
    cmp("dropcount", {24'd0, o_DropCount}, {24'd0, e_cnt[7:0]});
    cmp("clipped", {31'd0, o_Clipped}, {31'd0, e_clip});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic send_frame(input logic signed [15:0] val);
    for (int i = 0; i < 16; i++) begin
      sv = 1; svc = i[3:0]; sub = val; fe = (i == 15);
      step();
    end
    sv = 0; fe = 0;
  endtask

  function automatic logic [31:0] both(input int v);
    logic [15:0] h;
    h = 16'(v);
    return {h, h};
  endfunction

  int dq [4] = '{2, 3, 4, 6};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_sample", o_Sample, 32'h0);
    cmp("rst_valid", {31'd0, o_SampleValid}, 32'd0);
    cmp("rst_dropcnt", {24'd0, o_DropCount}, 32'd0);
    cmp("rst_clip", {31'd0, o_Clipped}, 32'd0);
    rst_n = 1;

    // Plain sum: 16 x 0x1000 >>> 2 = 0x4000 per channel.
    send_frame(16'sh1000);
    cmp("lat_n1", {31'd0, o_SampleValid}, 32'd0);
    step();
    cmp("lat_n2", {31'd0, o_SampleValid}, 32'd1);
    cmp("sum", o_Sample, 32'h4000_4000);
    rdy = 1; step(); rdy = 0;

    // Mask routing with a coincident write on voice 0.
    mwe = 1; mv = 0; mval = 2'b01; step();
    mv = 1; mval = 2'b10; step();
    mv = 0; mval = 2'b10;
    sv = 1; svc = 0; sub = 16'sd1600; step();
    mwe = 0; svc = 1; sub = -16'sd320; fe = 1; step();
    sv = 0; fe = 0; step();
    cmp("mask", o_Sample, 32'hFFB0_0190);
    rdy = 1; step(); rdy = 0;
    mwe = 1; mv = 0; mval = 2'b11; step();
    mv = 1; step();
    mwe = 0;

    // Overflow: 16 x 32767 >>> 2 = 0x1FFFC.
    send_frame(16'sd32767);
    step();
`ifdef SYNTH_MIXER_SATURATE_EN
    cmp("ovf", o_Sample, 32'h7FFF_7FFF);
    cmp("ovf_clip", {31'd0, o_Clipped}, 32'd1);
`else
    cmp("ovf", o_Sample, 32'hFFFC_FFFC);
    cmp("ovf_clip", {31'd0, o_Clipped}, 32'd0);
`endif
    rdy = 1; step(); rdy = 0;

    // Frame end without valid is ignored.
    fe = 1; step(); fe = 0; step();
    cmp("fe_novalid", {31'd0, o_SampleValid}, 32'd0);

    // Back-pressure: 5 frames into a depth-4 FIFO.
    for (int k = 1; k <= 5; k++) send_frame(16'(k));
    step(); step();
    cmp("bp_dropcnt", {24'd0, o_DropCount}, 32'd1);
    cmp("bp_head", o_Sample, both(4));

    // Full FIFO, pop in the push cycle: frame 6 goes to the tail.
    send_frame(16'sd6);
    cmp("fp_head", o_Sample, both(4));
    rdy = 1; step(); rdy = 0;
    step();
    cmp("fp_dropcnt", {24'd0, o_DropCount}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cmp("drain", o_Sample, both(4 * dq[i]));
      rdy = 1; step(); rdy = 0;
    end
    cmp("drained", {31'd0, o_SampleValid}, 32'd0);

    // Mid-frame reset with a frame queued.
    send_frame(16'sd5);
    step();
    for (int i = 0; i < 7; i++) begin
      sv = 1; svc = i[3:0]; sub = 16'sd100; step();
    end
    rst_n = 0;
    model_reset();
    #1;
    cmp("mrst_valid", {31'd0, o_SampleValid}, 32'd0);
    cmp("mrst_sample", o_Sample, 32'h0);
    cmp("mrst_dropcnt", {24'd0, o_DropCount}, 32'd0);
    sv = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    send_frame(16'sd3);
    step();
    cmp("post_rst", o_Sample, both(12));
    rdy = 1; step(); rdy = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
